// File: rtl/piso_pkg.sv
`default_nettype none
// ============================================================================
// Module      : piso_pkg
// Description : Shared types and helpers for the piso_stream serialiser.
//               Holds the FSM state encoding and the beat-counter width
//               helper used by the top and its testbench.
// Revision    : 1.0  initial release
// ============================================================================
package piso_pkg;

  // IDLE : no word held.  SHIFT : word held, bits still pending.
  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } piso_state_t;

  // Beat counter width for a word of w bits; never narrower than one bit.
  function automatic int piso_cnt_width(input int w);
    return (w <= 2) ? 1 : $clog2(w);
  endfunction

endpackage : piso_pkg
`default_nettype wire

// File: rtl/piso_stream_if.sv
`default_nettype none
// ============================================================================
// Module      : piso_stream_if
// Description : Parallel-in / serial-out stream bundle.
//               master : drives the parallel word, fill bit and the serial
//                        ready (the producer/consumer side).
//               slave  : the serialiser itself.
// Signals     : PI[WIDTH-1:0], PI_VALID, PI_READY  parallel load handshake
//               SI                                 serial fill bit
//               SO, SO_VALID, SO_READY, SO_LAST    serial output handshake
// Revision    : 1.0  initial release
// ============================================================================
interface piso_stream_if #(
  parameter int WIDTH = 10
);
  logic [WIDTH-1:0] PI;
  logic             PI_VALID;
  logic             PI_READY;
  logic             SI;
  logic             SO;
  logic             SO_VALID;
  logic             SO_READY;
  logic             SO_LAST;

  modport master (
    output PI, PI_VALID, SI, SO_READY,
    input  PI_READY, SO, SO_VALID, SO_LAST
  );

  modport slave (
    input  PI, PI_VALID, SI, SO_READY,
    output PI_READY, SO, SO_VALID, SO_LAST
  );
endinterface : piso_stream_if
`default_nettype wire

// File: rtl/piso_shift_reg.sv
`default_nettype none
// ============================================================================
// Module      : piso_shift_reg
// Description : Loadable shift register. A load captures i_pi; a shift moves
//               the contents one place toward the output end and inserts
//               i_si at the opposite end. Load has priority over shift.
// Ports       : i_clk, i_rst_n      clock, async active-low reset
//               i_load, i_pi        parallel load strobe and data
//               i_shift, i_si       shift strobe and fill bit
//               o_so                bit at the output end
//               o_sreg              full register contents
// Revision    : 1.0  initial release
// ============================================================================
module piso_shift_reg
  import piso_pkg::*;
#(
  parameter int WIDTH     = 10,
  parameter bit MSB_FIRST = 1'b1
) (
  input  wire logic             i_clk,
  input  wire logic             i_rst_n,
  input  wire logic             i_load,
  input  wire logic [WIDTH-1:0] i_pi,
  input  wire logic             i_shift,
  input  wire logic             i_si,
  output logic                  o_so,
  output logic [WIDTH-1:0]      o_sreg
);

  logic [WIDTH-1:0] r_sreg;
  logic [WIDTH-1:0] w_shifted;

  generate
    if (MSB_FIRST) begin : g_msb_first
      // Output end is the top bit; fill enters at bit 0.
      assign w_shifted = {r_sreg[WIDTH-2:0], i_si};
      assign o_so      = r_sreg[WIDTH-1];
    end else begin : g_lsb_first
      // Output end is bit 0; fill enters at the top bit.
      assign w_shifted = {i_si, r_sreg[WIDTH-1:1]};
      assign o_so      = r_sreg[0];
    end
  endgenerate

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sreg <= '0;
    end else if (i_load) begin
      r_sreg <= i_pi;
    end else if (i_shift) begin
      r_sreg <= w_shifted;
    end
  end

  assign o_sreg = r_sreg;

endmodule : piso_shift_reg
`default_nettype wire

// File: rtl/piso_stream.sv
`default_nettype none
// ============================================================================
// Module      : piso_stream
// Description : Parallel-in / serial-out streamer with valid/ready on both
//               sides. A word is loaded into the shift register and sent one
//               bit per accepted beat; the last beat can reload the next word
//               in the same cycle so consecutive words have no bubble.
// Ports       : CLK          clock, rising edge
//               ASYNCRESETN  asynchronous active-low reset
//               bus          piso_stream_if.slave (PI/PI_VALID/PI_READY,
//                            SI, SO/SO_VALID/SO_READY/SO_LAST)
// Revision    : 1.0  initial release
// ============================================================================
module piso_stream
  import piso_pkg::*;
#(
  parameter int WIDTH     = 10,
  parameter bit MSB_FIRST = 1'b1
) (
  input  wire logic     CLK,
  input  wire logic     ASYNCRESETN,
  piso_stream_if.slave  bus
);

  localparam int             CW     = piso_cnt_width(WIDTH);
  localparam logic [CW-1:0]  c_LAST = CW'(WIDTH - 1);

  piso_state_t      r_state;
  logic [CW-1:0]    r_cnt;

  logic             w_shift_st;
  logic             w_last;
  logic             w_ready;
  logic             w_load;
  logic             w_beat;
  logic             w_so;
  logic [WIDTH-1:0] w_sreg;

  assign w_shift_st = (r_state == SHIFT);
  assign w_last     = w_shift_st && (r_cnt == c_LAST);
  // Ready while empty, or on the final beat so the next word follows directly.
  assign w_ready    = (r_state == IDLE) || (w_last && bus.SO_READY);
  assign w_load     = bus.PI_VALID && w_ready;
  assign w_beat     = w_shift_st && bus.SO_READY;

  always_ff @(posedge CLK or negedge ASYNCRESETN) begin
    if (!ASYNCRESETN) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else if (w_load) begin
      r_state <= SHIFT;
      r_cnt   <= '0;
    end else if (w_beat) begin
      if (w_last) begin
        r_state <= IDLE;
        r_cnt   <= '0;
      end else begin
        r_cnt   <= r_cnt + CW'(1);
      end
    end
  end

  // A reload on the final beat overwrites the register instead of shifting.
  piso_shift_reg #(
    .WIDTH     (WIDTH),
    .MSB_FIRST (MSB_FIRST)
  ) u_sreg (
    .i_clk   (CLK),
    .i_rst_n (ASYNCRESETN),
    .i_load  (w_load),
    .i_pi    (bus.PI),
    .i_shift (w_beat && !w_load),
    .i_si    (bus.SI),
    .o_so    (w_so),
    .o_sreg  (w_sreg)
  );

  assign bus.PI_READY = w_ready;
  assign bus.SO_VALID = w_shift_st;
  // Register may hold fill bits once the word is done; keep SO quiet in IDLE.
  assign bus.SO       = w_shift_st & w_so;
  assign bus.SO_LAST  = w_last;

endmodule : piso_stream
`default_nettype wire
